// File: rtl/ras_if.sv
// rtl/ras_if.sv - return address stack request/response bundle
interface ras_if #(
  parameter int RAS_DEPTH        = 8,
  parameter int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH),
  parameter int RAS_TARGET_WIDTH = 12
);
  logic                        link_valid;
  logic [RAS_TARGET_WIDTH-1:0] link_target;
  logic                        ret_valid;
  logic [RAS_TARGET_WIDTH-1:0] ret_target;
  logic                        ret_empty;
  logic [LOG_RAS_DEPTH-1:0]    ras_index;
  logic [LOG_RAS_DEPTH:0]      ras_count;
  logic                        restore_valid;
  logic [LOG_RAS_DEPTH-1:0]    restore_index;
  logic [LOG_RAS_DEPTH:0]      restore_count;

  // Predictor / backend side: issues calls, returns and restores
  modport master (
    output link_valid, link_target, ret_valid,
    output restore_valid, restore_index, restore_count,
    input  ret_target, ret_empty, ras_index, ras_count
  );

  // Stack side
  modport slave (
    input  link_valid, link_target, ret_valid,
    input  restore_valid, restore_index, restore_count,
    output ret_target, ret_empty, ras_index, ras_count
  );
endinterface

// File: rtl/ras.sv
// rtl/ras.sv - circular return address stack with checkpoint restore
module ras #(
  parameter int RAS_DEPTH        = 8,
  parameter int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH),
  parameter int RAS_TARGET_WIDTH = 12
) (
  input logic CLK,
  input logic nRST,
  ras_if.slave bus
);
  localparam int CW = LOG_RAS_DEPTH + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [RAS_TARGET_WIDTH-1:0] entries [RAS_DEPTH];
  logic [LOG_RAS_DEPTH-1:0]    tos;
  logic [CW-1:0]               count;
  logic [LOG_RAS_DEPTH-1:0]    tos_inc;
  logic [LOG_RAS_DEPTH-1:0]    tos_dec;

  // Pointer neighbours wrap naturally at the pointer width
  always_comb begin
    tos_inc = tos + 1'b1;
    tos_dec = tos - 1'b1;
  end

  assign bus.ret_target = entries[tos];
  assign bus.ret_empty  = (count == '0);
  assign bus.ras_index  = tos;
  assign bus.ras_count  = count;

  // Stack update: restore beats call+return beats push beats pop
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tos   <= '0;
      count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) entries[i] <= '0;
    end else if (bus.restore_valid) begin
      tos   <= bus.restore_index;
      count <= (bus.restore_count > FULL) ? FULL : bus.restore_count;
    end else if (bus.link_valid && bus.ret_valid) begin
      // Tail call: replace the top in place
      entries[tos] <= bus.link_target;
      if (count == '0) count <= CW'(1);
    end else if (bus.link_valid) begin
      // When full the write lands on the oldest slot and count saturates
      entries[tos_inc] <= bus.link_target;
      tos              <= tos_inc;
      if (count != FULL) count <= count + 1'b1;
    end else if (bus.ret_valid && count != '0) begin
      tos   <= tos_dec;
      count <= count - 1'b1;
    end
  end
endmodule

// File: tb/tb_ras.sv
// tb/tb_ras.sv - directed self-checking bench for ras
module tb_ras;
  logic CLK;
  logic nRST;
  int   n_cmp;
  int   n_fail;

  ras_if bus ();

  ras dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic set_in(input logic lv, input logic [11:0] lt, input logic rv,
                        input logic sv, input logic [2:0] si, input logic [3:0] sc);
    bus.link_valid    = lv;
    bus.link_target   = lt;
    bus.ret_valid     = rv;
    bus.restore_valid = sv;
    bus.restore_index = si;
    bus.restore_count = sc;
  endtask

  task automatic idle();
    set_in(1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 4'd0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [11:0] t);
    set_in(1'b1, t, 1'b0, 1'b0, 3'd0, 4'd0);
    tick();
    idle();
  endtask

  task automatic pop();
    set_in(1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 4'd0);
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    nRST = 1'b0;
    #2;
    n_cmp++;
    if (bus.ret_target !== 12'h000) begin n_fail++; $display("FAIL reset_target got %h want 000", bus.ret_target); end
    n_cmp++;
    if (bus.ret_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", bus.ret_empty); end
    n_cmp++;
    if (bus.ras_index !== 3'd0) begin n_fail++; $display("FAIL reset_index got %0d want 0", bus.ras_index); end
    n_cmp++;
    if (bus.ras_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.ras_count); end
    tick();
    nRST = 1'b1;
    #1;
  endtask

  task automatic test_push_pop();
    logic [11:0] exp_t [3];
    exp_t[0] = 12'h333; exp_t[1] = 12'h222; exp_t[2] = 12'h111;
    do_reset();
    push(12'h111);
    push(12'h222);
    push(12'h333);
    n_cmp++;
    if (bus.ras_index !== 3'd3) begin n_fail++; $display("FAIL pp_index got %0d want 3", bus.ras_index); end
    n_cmp++;
    if (bus.ras_count !== 4'd3) begin n_fail++; $display("FAIL pp_count got %0d want 3", bus.ras_count); end
    n_cmp++;
    if (bus.ret_target !== 12'h333) begin n_fail++; $display("FAIL pp_top got %h want 333", bus.ret_target); end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 4'd0);
      #1;
      n_cmp++;
      if (bus.ret_target !== exp_t[i]) begin n_fail++; $display("FAIL pp_pop%0d got %h want %h", i, bus.ret_target, exp_t[i]); end
      tick();
    end
    idle();
    n_cmp++;
    if (bus.ret_empty !== 1'b1) begin n_fail++; $display("FAIL pp_empty got %b want 1", bus.ret_empty); end
    n_cmp++;
    if (bus.ras_index !== 3'd0) begin n_fail++; $display("FAIL pp_final_index got %0d want 0", bus.ras_index); end
  endtask

  task automatic test_overflow_underflow();
    logic [11:0] exp_t [8];
    exp_t[0] = 12'h00A; exp_t[1] = 12'h009; exp_t[2] = 12'h008; exp_t[3] = 12'h007;
    exp_t[4] = 12'h006; exp_t[5] = 12'h005; exp_t[6] = 12'h004; exp_t[7] = 12'h003;
    do_reset();
    for (int k = 1; k <= 10; k++) push(12'(k));
    n_cmp++;
    if (bus.ras_count !== 4'd8) begin n_fail++; $display("FAIL ov_count got %0d want 8", bus.ras_count); end
    n_cmp++;
    if (bus.ret_target !== 12'h00A) begin n_fail++; $display("FAIL ov_top got %h want 00a", bus.ret_target); end
    n_cmp++;
    if (bus.ras_index !== 3'd2) begin n_fail++; $display("FAIL ov_index got %0d want 2", bus.ras_index); end
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 4'd0);
      #1;
      n_cmp++;
      if (bus.ret_target !== exp_t[i]) begin n_fail++; $display("FAIL ov_pop%0d got %h want %h", i, bus.ret_target, exp_t[i]); end
      tick();
    end
    // Underflow: stale top still driven, pointer and count frozen
    set_in(1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 4'd0);
    #1;
    n_cmp++;
    if (bus.ret_target !== 12'h00A) begin n_fail++; $display("FAIL un_stale got %h want 00a", bus.ret_target); end
    tick();
    idle();
    n_cmp++;
    if (bus.ras_count !== 4'd0) begin n_fail++; $display("FAIL un_count got %0d want 0", bus.ras_count); end
    n_cmp++;
    if (bus.ras_index !== 3'd2) begin n_fail++; $display("FAIL un_index got %0d want 2", bus.ras_index); end
  endtask

  task automatic test_call_through_return();
    do_reset();
    push(12'h0AA);
    set_in(1'b1, 12'h0BB, 1'b1, 1'b0, 3'd0, 4'd0);
    #1;
    n_cmp++;
    if (bus.ret_target !== 12'h0AA) begin n_fail++; $display("FAIL ctr_same got %h want 0aa", bus.ret_target); end
    tick();
    idle();
    n_cmp++;
    if (bus.ret_target !== 12'h0BB) begin n_fail++; $display("FAIL ctr_next got %h want 0bb", bus.ret_target); end
    n_cmp++;
    if (bus.ras_index !== 3'd1) begin n_fail++; $display("FAIL ctr_index got %0d want 1", bus.ras_index); end
    n_cmp++;
    if (bus.ras_count !== 4'd1) begin n_fail++; $display("FAIL ctr_count got %0d want 1", bus.ras_count); end
  endtask

  task automatic test_restore();
    logic [2:0] cap_i;
    logic [3:0] cap_c;
    do_reset();
    push(12'h100);
    push(12'h200);
    cap_i = bus.ras_index;
    cap_c = bus.ras_count;
    n_cmp++;
    if (cap_i !== 3'd2 || cap_c !== 4'd2) begin n_fail++; $display("FAIL rs_capture got %0d/%0d want 2/2", cap_i, cap_c); end
    push(12'h300);
    pop();
    pop();
    set_in(1'b1, 12'hFFF, 1'b0, 1'b1, 3'd2, 4'd2);
    tick();
    idle();
    n_cmp++;
    if (bus.ret_target !== 12'h200) begin n_fail++; $display("FAIL rs_target got %h want 200", bus.ret_target); end
    n_cmp++;
    if (bus.ras_count !== 4'd2) begin n_fail++; $display("FAIL rs_count got %0d want 2", bus.ras_count); end
    n_cmp++;
    if (bus.ras_index !== 3'd2) begin n_fail++; $display("FAIL rs_index got %0d want 2", bus.ras_index); end
    // The ignored push must not have touched the slot above the top
    push(12'h400);
    pop();
    n_cmp++;
    if (bus.ret_target !== 12'h200) begin n_fail++; $display("FAIL rs_after got %h want 200", bus.ret_target); end
  endtask

  task automatic test_restore_clamp();
    do_reset();
    set_in(1'b0, 12'h000, 1'b0, 1'b1, 3'd5, 4'd15);
    tick();
    idle();
    n_cmp++;
    if (bus.ras_count !== 4'd8) begin n_fail++; $display("FAIL clamp_count got %0d want 8", bus.ras_count); end
    n_cmp++;
    if (bus.ras_index !== 3'd5) begin n_fail++; $display("FAIL clamp_index got %0d want 5", bus.ras_index); end
    set_in(1'b0, 12'h000, 1'b0, 1'b1, 3'd5, 4'd0);
    tick();
    pop();
    n_cmp++;
    if (bus.ras_index !== 3'd5) begin n_fail++; $display("FAIL clamp_under_index got %0d want 5", bus.ras_index); end
    n_cmp++;
    if (bus.ras_count !== 4'd0) begin n_fail++; $display("FAIL clamp_under_count got %0d want 0", bus.ras_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 8; k++) push(12'h501 + 12'(k));
    n_cmp++;
    if (bus.ras_count !== 4'd8) begin n_fail++; $display("FAIL ar_full got %0d want 8", bus.ras_count); end
    set_in(1'b1, 12'hEEE, 1'b0, 1'b0, 3'd0, 4'd0);
    #2;
    nRST = 1'b0;
    #1;
    n_cmp++;
    if (bus.ret_target !== 12'h000) begin n_fail++; $display("FAIL ar_target got %h want 000", bus.ret_target); end
    n_cmp++;
    if (bus.ras_count !== 4'd0 || bus.ras_index !== 3'd0 || bus.ret_empty !== 1'b1)
      begin n_fail++; $display("FAIL ar_state got c%0d i%0d e%b want c0 i0 e1", bus.ras_count, bus.ras_index, bus.ret_empty); end
    idle();
    #1;
    nRST = 1'b1;
    tick();
    push(12'h777);
    n_cmp++;
    if (bus.ras_index !== 3'd1) begin n_fail++; $display("FAIL ar_push_index got %0d want 1", bus.ras_index); end
    n_cmp++;
    if (bus.ret_target !== 12'h777) begin n_fail++; $display("FAIL ar_push_target got %h want 777", bus.ret_target); end
    n_cmp++;
    if (bus.ras_count !== 4'd1) begin n_fail++; $display("FAIL ar_push_count got %0d want 1", bus.ras_count); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    nRST   = 1'b0;
    idle();
    test_reset();
    test_push_pop();
    test_overflow_underflow();
    test_call_through_return();
    test_restore();
    test_restore_clamp();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
